// File: rtl/spi_master_txrx_pkg.sv
// ============================================================================
//  Module      : spi_master_txrx_pkg
//  Description : Shared SPI master definitions: FSM state encoding and the
//                SCLK half-period divider formula.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_master_txrx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    function automatic int half_div(input int ref_clk, input int spi_sclk);
        return ref_clk / (2 * spi_sclk);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ============================================================================
//  Module      : spi_clk_div
//  Description : Half-period tick generator; one tick every HALF_DIV enabled
//                cycles, counter restarts whenever In_en is low.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_clk_div #(
    parameter int HALF_DIV = 50
) (
    input  logic In_clk,
    input  logic In_rst_n,
    input  logic In_en,
    output logic Out_tick
);

    localparam int                 c_CNT_W = $clog2(HALF_DIV + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            r_cnt <= '0;
        end else if (!In_en || r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Out_tick = In_en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/spi_master_txrx.sv
// ============================================================================
//  Module      : spi_master_txrx
//  Description : Parametrised full-duplex SPI master (any CPOL/CPHA, word
//                width and bit order) with tx_req/busy handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master_txrx
    import spi_master_txrx_pkg::*;
#(
    parameter int REF_CLK   = 50_000_000,
    parameter int SPI_SCLK  = 500_000,
    parameter int DATA_W    = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              In_clk,
    input  logic              In_rst_n,
    input  logic              In_tx_req,
    input  logic [DATA_W-1:0] In_tx_data,
    input  logic              In_spi_miso,
    output logic              Out_tx_busy,
    output logic              Out_rx_valid,
    output logic [DATA_W-1:0] Out_rx_data,
    output logic              Out_spi_cs_n,
    output logic              Out_spi_sclk,
    output logic              Out_spi_mosi
);

    localparam int                  c_HALF_DIV  = half_div(REF_CLK, SPI_SCLK);
    localparam int                  c_EDGES     = 2 * DATA_W;
    localparam int                  c_EDGE_W    = $clog2(c_EDGES + 1);
    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(c_EDGES);

    generate
        if (c_HALF_DIV < 1 || DATA_W < 2) begin : g_bad_params
            $error("spi_master_txrx: HALF_DIV must be >= 1 and DATA_W >= 2");
        end
    endgenerate

    spi_state_e          r_state, w_state_nxt;
    logic [c_EDGE_W-1:0] r_edge_cnt, w_edge_cnt_nxt, w_edge_num;
    logic [DATA_W-1:0]   r_tx_shift, w_tx_shift_nxt;
    logic [DATA_W-1:0]   r_rx_shift, w_rx_shift_nxt;
    logic [DATA_W-1:0]   r_rx_data, w_rx_data_nxt;
    logic                r_rx_valid, w_rx_valid_nxt;
    logic                r_cs_n, w_cs_n_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_mosi, w_mosi_nxt;
    logic                w_tick, w_do_sample, w_do_shift;

    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
    endfunction

    spi_clk_div #(
        .HALF_DIV (c_HALF_DIV)
    ) u_clk_div (
        .In_clk   (In_clk),
        .In_rst_n (In_rst_n),
        .In_en    (r_state != ST_IDLE),
        .Out_tick (w_tick)
    );

    assign w_edge_num = r_edge_cnt + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_edge_cnt_nxt = r_edge_cnt;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_cs_n_nxt     = r_cs_n;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_do_sample    = 1'b0;
        w_do_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (In_tx_req) begin
                    w_state_nxt    = ST_SETUP;
                    w_edge_cnt_nxt = '0;
                    w_cs_n_nxt     = 1'b0;
                    w_rx_shift_nxt = '0;
                    // CPHA=0 slaves expect the first bit before the first edge
                    if (CPHA) begin
                        w_tx_shift_nxt = In_tx_data;
                        w_mosi_nxt     = 1'b0;
                    end else begin
                        w_tx_shift_nxt = shift_out(In_tx_data);
                        w_mosi_nxt     = head_bit(In_tx_data);
                    end
                end
            end
            ST_SETUP, ST_SHIFT: begin
                if (w_tick) begin
                    w_edge_cnt_nxt = w_edge_num;
                    w_sclk_nxt     = ~r_sclk;
                    // Odd edges are leading edges; the final edge never shifts
                    w_do_sample    = (w_edge_num[0] != CPHA);
                    w_do_shift     = (w_edge_num[0] == CPHA) && (w_edge_num != c_LAST_EDGE);
                    if (w_do_sample) begin
                        w_rx_shift_nxt = shift_in(r_rx_shift, In_spi_miso);
                    end
                    if (w_do_shift) begin
                        w_mosi_nxt     = head_bit(r_tx_shift);
                        w_tx_shift_nxt = shift_out(r_tx_shift);
                    end
                    w_state_nxt = (w_edge_num == c_LAST_EDGE) ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_rx_data_nxt  = r_rx_shift;
                    w_rx_valid_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            r_state    <= ST_IDLE;
            r_edge_cnt <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cs_n     <= 1'b1;
            r_sclk     <= CPOL;
            r_mosi     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
        end
    end

    assign Out_tx_busy  = (r_state != ST_IDLE);
    assign Out_rx_valid = r_rx_valid;
    assign Out_rx_data  = r_rx_data;
    assign Out_spi_cs_n = r_cs_n;
    assign Out_spi_sclk = r_sclk;
    assign Out_spi_mosi = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_txrx.sv
// ============================================================================
//  Module      : tb_spi_master_txrx
//  Description : Four differently configured SPI masters driven with directed
//                and random words against a pin-level slave/timing model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`define CHK(TAG, OBS, EXP) \
    begin \
        vectors++; \
        assert ((OBS) === (EXP)) else begin \
            miscompares++; \
            $error("FAIL %s: observed %0h, expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_spi_master_txrx;

    localparam int c_N = 4;

    // Per-instance configuration, must match the instances below
    int hd   [c_N] = '{50, 2, 3, 1};
    int dw   [c_N] = '{8, 8, 16, 8};
    bit cpol [c_N] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit cpha [c_N] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit msbf [c_N] = '{1'b1, 1'b1, 1'b0, 1'b1};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int g_rise      = 0;

    logic        clk = 1'b0;
    logic        rstn [c_N];
    logic        req  [c_N];
    logic [15:0] txd  [c_N];
    logic        sdrv [c_N];
    logic        lp   [c_N];

    wire         busy [c_N];
    wire         vld  [c_N];
    wire         csn  [c_N];
    wire         sclk [c_N];
    wire         mosi [c_N];
    wire         miso [c_N];
    wire  [15:0] rxd  [c_N];

    logic [7:0]  rx0, rx1, rx3;
    logic [15:0] rx2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rxd[0] = {8'h00, rx0};
    assign rxd[1] = {8'h00, rx1};
    assign rxd[2] = rx2;
    assign rxd[3] = {8'h00, rx3};

    genvar gk;
    generate
        for (gk = 0; gk < c_N; gk++) begin : g_miso
            assign miso[gk] = lp[gk] ? mosi[gk] : sdrv[gk];
        end
    endgenerate

    spi_master_txrx #(.REF_CLK(50_000_000), .SPI_SCLK(500_000), .DATA_W(8),
                      .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut0 (
        .In_clk(clk), .In_rst_n(rstn[0]), .In_tx_req(req[0]), .In_tx_data(txd[0][7:0]),
        .In_spi_miso(miso[0]), .Out_tx_busy(busy[0]), .Out_rx_valid(vld[0]), .Out_rx_data(rx0),
        .Out_spi_cs_n(csn[0]), .Out_spi_sclk(sclk[0]), .Out_spi_mosi(mosi[0]));

    spi_master_txrx #(.REF_CLK(8), .SPI_SCLK(2), .DATA_W(8),
                      .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_dut1 (
        .In_clk(clk), .In_rst_n(rstn[1]), .In_tx_req(req[1]), .In_tx_data(txd[1][7:0]),
        .In_spi_miso(miso[1]), .Out_tx_busy(busy[1]), .Out_rx_valid(vld[1]), .Out_rx_data(rx1),
        .Out_spi_cs_n(csn[1]), .Out_spi_sclk(sclk[1]), .Out_spi_mosi(mosi[1]));

    spi_master_txrx #(.REF_CLK(6), .SPI_SCLK(1), .DATA_W(16),
                      .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u_dut2 (
        .In_clk(clk), .In_rst_n(rstn[2]), .In_tx_req(req[2]), .In_tx_data(txd[2]),
        .In_spi_miso(miso[2]), .Out_tx_busy(busy[2]), .Out_rx_valid(vld[2]), .Out_rx_data(rx2),
        .Out_spi_cs_n(csn[2]), .Out_spi_sclk(sclk[2]), .Out_spi_mosi(mosi[2]));

    spi_master_txrx #(.REF_CLK(2), .SPI_SCLK(1), .DATA_W(8),
                      .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_dut3 (
        .In_clk(clk), .In_rst_n(rstn[3]), .In_tx_req(req[3]), .In_tx_data(txd[3][7:0]),
        .In_spi_miso(miso[3]), .Out_tx_busy(busy[3]), .Out_rx_valid(vld[3]), .Out_rx_data(rx3),
        .Out_spi_cs_n(csn[3]), .Out_spi_sclk(sclk[3]), .Out_spi_mosi(mosi[3]));

    function automatic logic bit_at(input logic [15:0] w, input int d, input int k, input bit msb);
        return msb ? w[d-1-k] : w[k];
    endfunction

    // One transaction on instance i, entered and left on a falling clock edge.
    // The model acts as a real slave: it watches SCLK and drives/samples on its edges.
    task automatic xfer(input int i, input logic [15:0] tx_in, input logic [15:0] sw_in,
                        input bit lpbk, input bit hold, input bit chk_gap,
                        input int rst_edge, input bit poke);
        int h, d, n_busy, n_cslo, first_lo, n_tog, bad_tog, n_vld, m_cnt, s_idx, bad_mosi, bound;
        bit did_rst;
        logic prev_sclk, prev_mosi, prev_cs, lead;
        logic [15:0] tx, sw, got_mosi, exp_rx, mask;
        h = hd[i];
        d = dw[i];
        mask = (d == 16) ? 16'hFFFF : 16'h00FF;
        tx = tx_in & mask;
        sw = sw_in & mask;
        exp_rx = lpbk ? tx : sw;
        lp[i] = lpbk;
        txd[i] = tx;
        req[i] = 1'b1;
        s_idx = cpha[i] ? 0 : 1;
        sdrv[i] = cpha[i] ? 1'b0 : bit_at(sw, d, 0, msbf[i]);
        n_busy = 0; n_cslo = 0; first_lo = -1; n_tog = 0; bad_tog = 0;
        n_vld = 0; m_cnt = 0; bad_mosi = 0; got_mosi = '0; did_rst = 1'b0;
        prev_sclk = sclk[i]; prev_mosi = mosi[i]; prev_cs = csn[i];
        bound = (2 * d + 2) * h + 4;
        @(posedge clk);
        if (!hold) begin
            #1 req[i] = 1'b0;
        end
        for (int t = 1; t <= bound; t++) begin
            @(negedge clk);
            if (poke && t == 5 * h + 1) begin
                req[i] = 1'b1;
                txd[i] = ~tx & mask;
            end
            if (poke && t == 5 * h + 2) req[i] = 1'b0;
            if (busy[i] === 1'b1) n_busy++;
            if (csn[i] === 1'b0) begin
                n_cslo++;
                if (first_lo < 0) begin
                    first_lo = t;
                    if (chk_gap) `CHK("cs_gap", cyc - g_rise, h + 1)
                end
            end
            if (csn[i] === 1'b1 && prev_cs === 1'b0) g_rise = cyc;
            if (csn[i] === 1'b1 && mosi[i] !== 1'b0) bad_mosi++;
            lead = (prev_sclk === cpol[i]);
            if (sclk[i] !== prev_sclk) begin
                n_tog++;
                if (t != n_tog * h + 1) bad_tog++;
                if (lead != cpha[i]) begin
                    if (m_cnt < d) got_mosi[msbf[i] ? d - 1 - m_cnt : m_cnt] = mosi[i];
                    m_cnt++;
                end else begin
                    if (s_idx < d) sdrv[i] = bit_at(sw, d, s_idx, msbf[i]);
                    s_idx++;
                end
            end
            if (mosi[i] !== prev_mosi && t > 1 && csn[i] === 1'b0 &&
                !(sclk[i] !== prev_sclk && lead == cpha[i])) bad_mosi++;
            if (vld[i] === 1'b1) begin
                n_vld++;
                `CHK("rx_valid_time", t, (2 * d + 2) * h + 1)
                `CHK("rx_data", rxd[i], exp_rx)
            end
            prev_sclk = sclk[i]; prev_mosi = mosi[i]; prev_cs = csn[i];
            if (rst_edge > 0 && n_tog == rst_edge) begin
                did_rst = 1'b1;
                break;
            end
            if (busy[i] === 1'b0) break;
        end
        if (did_rst) begin
            rstn[i] = 1'b0;
            #1;
            `CHK("rst_busy", busy[i], 1'b0)
            `CHK("rst_cs_n", csn[i], 1'b1)
            `CHK("rst_sclk", sclk[i], cpol[i])
            `CHK("rst_mosi", mosi[i], 1'b0)
            `CHK("rst_rx_data", rxd[i], 16'h0000)
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                `CHK("rst_no_valid", vld[i], 1'b0)
            end
            rstn[i] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                `CHK("post_rst_idle", {busy[i], vld[i], csn[i]}, 3'b001)
            end
        end else begin
            `CHK("busy_cycles", n_busy, (2 * d + 2) * h)
            `CHK("cs_low_cycles", n_cslo, (2 * d + 1) * h)
            `CHK("cs_first_low", first_lo, 1)
            `CHK("sclk_edges", n_tog, 2 * d)
            `CHK("sclk_spacing", bad_tog, 0)
            `CHK("mosi_stream", got_mosi, tx)
            `CHK("mosi_timing", bad_mosi, 0)
            `CHK("rx_valid_count", n_vld, 1)
            `CHK("rx_data_hold", rxd[i], exp_rx)
            if (!hold) begin
                @(negedge clk);
                `CHK("idle_valid_pulse", vld[i], 1'b0)
                `CHK("idle_busy", busy[i], 1'b0)
                `CHK("idle_cs_n", csn[i], 1'b1)
                `CHK("idle_sclk", sclk[i], cpol[i])
                `CHK("idle_mosi", mosi[i], 1'b0)
            end
        end
    endtask

    initial begin
        for (int k = 0; k < c_N; k++) begin
            rstn[k] = 1'b0; req[k] = 1'b0; txd[k] = '0; sdrv[k] = 1'b0; lp[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            `CHK("reset_busy", busy[k], 1'b0)
            `CHK("reset_valid", vld[k], 1'b0)
            `CHK("reset_rx_data", rxd[k], 16'h0000)
            `CHK("reset_cs_n", csn[k], 1'b1)
            `CHK("reset_sclk", sclk[k], cpol[k])
            `CHK("reset_mosi", mosi[k], 1'b0)
            rstn[k] = 1'b1;
        end
        @(negedge clk);

        // Mode 0 defaults, loopback, then random slave words
        xfer(0, 16'h00A5, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 2; k++) xfer(0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // CPOL=1 CPHA=1 against an independent slave
        xfer(1, 16'h003C, 16'h00C3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) xfer(1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // 16-bit LSB-first, back-to-back words, then mid-transfer request and reset
        xfer(2, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        xfer(2, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        xfer(2, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        xfer(2, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        xfer(2, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 7, 1'b1);
        xfer(2, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 0, 1'b1);

        // HALF_DIV=1, CPHA=1
        xfer(3, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        xfer(3, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0, 0, 1'b0);
        xfer(3, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b1, 0, 1'b0);
        xfer(3, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`undef CHK

`default_nettype wire
